// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: controller states, player and verdict codes,
// board size, and a square-to-bitmask helper.
package ttt_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WAIT = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int         NUM_SQUARES = 9;
    localparam logic [3:0] MAX_IDX     = 4'd8;

    // Out-of-range indices shift the bit off the top and yield an empty mask.
    function automatic logic [NUM_SQUARES-1:0] square_mask(input logic [3:0] idx);
        logic [NUM_SQUARES-1:0] one;
        one = NUM_SQUARES'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Move handshake, winner verdict and board/score outputs between the move
// decoder side (master) and the board-state writer (slave).
interface move_ctrl_if
    import ttt_pkg::*;
#(
    parameter int SCORE_W = 4
) ();
    logic                   move_valid;
    logic [3:0]             move_idx;
    logic                   new_game;
    logic                   game_over;
    logic [1:0]             display_winner;

    logic                   move_ready;
    logic                   move_err;
    logic [NUM_SQUARES-1:0] square1to9;
    logic [NUM_SQUARES-1:0] square1to9_color;
    logic                   current_player;
    logic [3:0]             move_count;
    logic [SCORE_W-1:0]     score_p1;
    logic [SCORE_W-1:0]     score_p2;
    logic [SCORE_W-1:0]     score_draw;

    modport master (
        output move_valid, move_idx, new_game, game_over, display_winner,
        input  move_ready, move_err, square1to9, square1to9_color,
               current_player, move_count, score_p1, score_p2, score_draw
    );

    modport slave (
        input  move_valid, move_idx, new_game, game_over, display_winner,
        output move_ready, move_err, square1to9, square1to9_color,
               current_player, move_count, score_p1, score_p2, score_draw
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by rst.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/move_ctrl.sv
// Board-state writer: accepts moves, alternates turns, waits for the winner
// verdict after each move, locks on game over and keeps saturating tallies.
module move_ctrl
    import ttt_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter int CHECK_LAT = 1
) (
    input  logic       pclk,
    input  logic       rst,
    move_ctrl_if.slave bus
);
    localparam int               CNT_W     = (CHECK_LAT < 1) ? 1 : $clog2(CHECK_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CHECK_LAT);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NUM_SQUARES-1:0] sq_q, sq_d;
    logic [NUM_SQUARES-1:0] col_q, col_d;
    logic                   player_q, player_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic [3:0]             count_q, count_d;

    logic [NUM_SQUARES-1:0] target;
    logic                   legal;
    logic [2:0]             score_inc;
    logic [SCORE_W-1:0]     score_val [3];

    assign target = square_mask(bus.move_idx);
    assign legal  = (bus.move_idx <= MAX_IDX) && ((sq_q & target) == '0);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sq_d       = sq_q;
        col_d      = col_q;
        player_d   = player_q;
        start_d    = start_q;
        count_d    = count_q;
        err_d      = 1'b0;
        score_inc  = '0;

        // new_game overrides both a pending accept and the verdict sample.
        if (bus.new_game) begin
            sq_d       = '0;
            col_d      = '0;
            count_d    = '0;
            start_d    = ~start_q;
            player_d   = ~start_q;
            wait_cnt_d = '0;
            state_d    = PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    if (bus.move_valid) begin
                        if (legal) begin
                            sq_d       = sq_q | target;
                            col_d      = col_q | (player_q ? target : '0);
                            player_d   = ~player_q;
                            count_d    = count_q + 4'd1;
                            wait_cnt_d = WAIT_LOAD;
                            state_d    = WAIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        if (bus.game_over) begin
                            state_d = OVER;
                            case (bus.display_winner)
                                WIN_P1:   score_inc[0] = 1'b1;
                                WIN_P2:   score_inc[1] = 1'b1;
                                WIN_DRAW: score_inc[2] = 1'b1;
                                default:  score_inc    = '0;
                            endcase
                        end else begin
                            state_d = PLAY;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q - CNT_W'(1);
                    end
                end
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= PLAY;
            wait_cnt_q <= '0;
            sq_q       <= '0;
            col_q      <= '0;
            player_q   <= P1;
            start_q    <= P1;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sq_q       <= sq_d;
            col_q      <= col_d;
            player_q   <= player_d;
            start_q    <= start_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Tallies in order: P1 wins, P2 wins, draws.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_score
            sat_counter #(.W(SCORE_W)) u_score (
                .clk   (pclk),
                .rst   (rst),
                .inc   (score_inc[gi]),
                .count (score_val[gi])
            );
        end
    endgenerate

    assign bus.move_ready       = (state_q == PLAY);
    assign bus.move_err         = err_q;
    assign bus.square1to9       = sq_q;
    assign bus.square1to9_color = col_q;
    assign bus.current_player   = player_q;
    assign bus.move_count       = count_q;
    assign bus.score_p1         = score_val[0];
    assign bus.score_p2         = score_val[1];
    assign bus.score_draw       = score_val[2];
endmodule

// File: tb/tb_move_ctrl.sv
// Self-checking bench for move_ctrl with a registered winner_check stand-in
// closing the loop and a scoreboard of expected board/score snapshots.
module tb_move_ctrl;
    import ttt_pkg::*;

    localparam int SCORE_W   = 4;
    localparam int CHECK_LAT = 1;
    localparam int SMAX      = (1 << SCORE_W) - 1;

    logic pclk;
    logic rst;

    move_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    move_ctrl #(.SCORE_W(SCORE_W), .CHECK_LAT(CHECK_LAT)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [1:0] judge(input logic [8:0] sq, input logic [8:0] col);
        int ln [8][3];
        ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int l = 0; l < 8; l++) begin
            if (sq[ln[l][0]] && sq[ln[l][1]] && sq[ln[l][2]] &&
                col[ln[l][0]] == col[ln[l][1]] && col[ln[l][1]] == col[ln[l][2]])
                return col[ln[l][0]] ? WIN_P2 : WIN_P1;
        end
        if (&sq) return WIN_DRAW;
        return WIN_NONE;
    endfunction

    // winner_check stand-in with one cycle of latency
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bus.game_over      <= 1'b0;
            bus.display_winner <= WIN_NONE;
        end else begin
            bus.display_winner <= judge(bus.square1to9, bus.square1to9_color);
            bus.game_over      <= (judge(bus.square1to9, bus.square1to9_color) != WIN_NONE);
        end
    end

    typedef struct {
        logic [8:0] sq;
        logic [8:0] col;
        logic       player;
        logic [3:0] count;
        logic       err;
        logic       ready;
        int         p1;
        int         p2;
        int         draw;
    } exp_t;

    exp_t sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] m_sq, m_col;
    logic       m_player, m_start, m_over;
    int         m_count, m_p1, m_p2, m_draw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sq = '0; m_col = '0; m_player = P1; m_start = P1; m_over = 1'b0;
        m_count = 0; m_p1 = 0; m_p2 = 0; m_draw = 0;
    endtask

    task automatic push_exp(input logic err, input logic rdy);
        exp_t e;
        e.sq = m_sq; e.col = m_col; e.player = m_player; e.count = 4'(m_count);
        e.err = err; e.ready = rdy; e.p1 = m_p1; e.p2 = m_p2; e.draw = m_draw;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        check_eq({tag, ".depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq({tag, ".sq"},     32'(bus.square1to9),       32'(e.sq));
            check_eq({tag, ".col"},    32'(bus.square1to9_color), 32'(e.col));
            check_eq({tag, ".player"}, 32'(bus.current_player),   32'(e.player));
            check_eq({tag, ".count"},  32'(bus.move_count),       32'(e.count));
            check_eq({tag, ".err"},    32'(bus.move_err),         32'(e.err));
            check_eq({tag, ".ready"},  32'(bus.move_ready),       32'(e.ready));
            check_eq({tag, ".p1"},     32'(bus.score_p1),         32'(e.p1));
            check_eq({tag, ".p2"},     32'(bus.score_p2),         32'(e.p2));
            check_eq({tag, ".draw"},   32'(bus.score_draw),       32'(e.draw));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.move_valid = 1'b0; bus.move_idx = '0; bus.new_game = 1'b0;
        @(posedge pclk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge pclk); #1;
        push_exp(1'b0, 1'b1);
        pop_cmp("reset");
        $display("reset done");
    endtask

    task automatic new_game();
        bus.new_game = 1'b1;
        @(posedge pclk); #1;
        bus.new_game = 1'b0;
        m_sq = '0; m_col = '0; m_count = 0; m_over = 1'b0;
        m_start = ~m_start; m_player = m_start;
        push_exp(1'b0, 1'b1);
        pop_cmp("new_game");
        $display("new_game start_player=%0d", m_start);
    endtask

    task automatic score_verdict();
        logic [1:0] w;
        w = judge(m_sq, m_col);
        if (w != WIN_NONE) begin
            m_over = 1'b1;
            if (w == WIN_P1)   m_p1   = (m_p1   < SMAX) ? m_p1 + 1   : SMAX;
            if (w == WIN_P2)   m_p2   = (m_p2   < SMAX) ? m_p2 + 1   : SMAX;
            if (w == WIN_DRAW) m_draw = (m_draw < SMAX) ? m_draw + 1 : SMAX;
        end
    endtask

    // Drives one move with the board model in step; abort pulses new_game in
    // the verdict-sampling cycle instead of letting the verdict land.
    task automatic move(input int idx, input bit abort);
        logic [8:0] oh;
        logic       legal;
        oh    = (idx <= 8) ? (9'd1 << idx) : 9'd0;
        legal = (idx <= 8) && ((m_sq & oh) == 9'd0);
        bus.move_valid = 1'b1;
        bus.move_idx   = idx[3:0];
        if (m_over) begin
            repeat (3) begin
                @(posedge pclk); #1;
                check_eq("over.err",   32'(bus.move_err),   32'd0);
                check_eq("over.ready", 32'(bus.move_ready), 32'd0);
            end
            bus.move_valid = 1'b0;
            push_exp(1'b0, 1'b0);
            pop_cmp("over_move");
            $display("move idx=%0d ignored (game over)", idx);
            return;
        end
        @(posedge pclk); #1;
        bus.move_valid = 1'b0;
        if (legal) begin
            m_sq = m_sq | oh;
            if (m_player) m_col = m_col | oh;
            m_player = ~m_player;
            m_count++;
            push_exp(1'b0, 1'b0);
            pop_cmp("accept");
            @(posedge pclk); #1;
            check_eq("wait.ready", 32'(bus.move_ready), 32'd0);
            check_eq("wait.err",   32'(bus.move_err),   32'd0);
            if (abort) begin
                new_game();
                @(posedge pclk); #1;
                push_exp(1'b0, 1'b1);
                pop_cmp("abort_settle");
            end else begin
                @(posedge pclk); #1;
                score_verdict();
                push_exp(1'b0, !m_over);
                pop_cmp("verdict");
            end
        end else begin
            push_exp(1'b1, 1'b1);
            pop_cmp("reject");
            @(posedge pclk); #1;
            push_exp(1'b0, 1'b1);
            pop_cmp("after_reject");
        end
        $display("move idx=%0d legal=%0d next_player=%0d count=%0d over=%0d",
                 idx, legal, m_player, m_count, m_over);
    endtask

    task automatic play_win(input logic winner, input bit abort);
        int w [3];
        int l [3];
        int seq [$];
        w = '{0, 1, 2};
        l = '{3, 4, 8};
        seq.delete();
        if (m_player == winner) seq = '{w[0], l[0], w[1], l[1], w[2]};
        else                    seq = '{l[0], w[0], l[1], w[1], l[2], w[2]};
        for (int i = 0; i < seq.size(); i++)
            move(seq[i], abort && (i == seq.size() - 1));
    endtask

    task automatic play_draw();
        int seq [9];
        seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        for (int i = 0; i < 9; i++) move(seq[i], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.move_valid = 1'b0; bus.move_idx = '0; bus.new_game = 1'b0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        @(posedge pclk); #1;
        push_exp(1'b0, 1'b1);
        pop_cmp("reset");

        move(4, 1'b0);
        check_eq("first.sq", 32'(bus.square1to9), 32'h010);
        move(4, 1'b0);
        move(9, 1'b0);

        do_reset();
        play_win(P1, 1'b0);
        check_eq("p1win.score", 32'(bus.score_p1), 32'd1);
        move(5, 1'b0);

        do_reset();
        play_draw();
        check_eq("draw.score", 32'(bus.score_draw), 32'd1);
        new_game();
        check_eq("draw.next_player", 32'(bus.current_player), 32'd1);

        for (int g = 0; g < 16; g++) begin
            play_win(P2, 1'b0);
            new_game();
        end
        check_eq("p2.saturated", 32'(bus.score_p2), 32'(SMAX));

        play_win(P1, 1'b1);

        // Reset asserted while the controller is waiting on a verdict.
        bus.move_valid = 1'b1;
        bus.move_idx   = 4'd0;
        @(posedge pclk); #1;
        bus.move_valid = 1'b0;
        m_sq = 9'h001;
        if (m_player) m_col = 9'h001;
        m_player = ~m_player;
        m_count = 1;
        push_exp(1'b0, 1'b0);
        pop_cmp("pre_rst");
        rst = 1'b1;
        #1;
        check_eq("rst.sq",     32'(bus.square1to9),       32'd0);
        check_eq("rst.col",    32'(bus.square1to9_color), 32'd0);
        check_eq("rst.player", 32'(bus.current_player),   32'd0);
        check_eq("rst.count",  32'(bus.move_count),       32'd0);
        check_eq("rst.err",    32'(bus.move_err),         32'd0);
        check_eq("rst.p1",     32'(bus.score_p1),         32'd0);
        check_eq("rst.p2",     32'(bus.score_p2),         32'd0);
        check_eq("rst.draw",   32'(bus.score_draw),       32'd0);
        #3;
        rst = 1'b0;
        model_reset();
        @(posedge pclk); #1;
        push_exp(1'b0, 1'b1);
        pop_cmp("post_rst");
        $display("reset mid-wait done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
